// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/MEM/EXEC with memory wait
// tracking, timeout fault, and absorbing HALTED/FAULT states.
module control_fsm #(
   parameter int unsigned SKIP_MEM = 1,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       bit20,
   input  logic       bit30,
   input  logic       cmp_out,
   input  logic       mem_ready,
   output logic [2:0] state,
   output logic       halted,
   output logic       fault,
   output logic       retire,
   output logic       pc_enable,
   output logic       pc_load,
   output logic       reg_re,
   output logic       reg_we,
   output logic       target_load,
   output logic       mem_addr_sel,
   output logic       inst_load,
   output logic       inst_mux_sel,
   output logic       alu_sel1,
   output logic       alu_sel2,
   output logic [4:0] alu_op,
   output logic [1:0] wd_sel,
   output logic [2:0] mem_read_op,
   output logic [1:0] mem_write_op
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] LW    = 3'b010;
   localparam logic [2:0] LNONE = 3'b111;
   localparam logic [1:0] SNONE = 2'b11;

   localparam bit             VISIT_MEM = (SKIP_MEM == 0);
   localparam bit             TO_EN     = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      MEM    = 3'd2,
      EXEC   = 3'd3,
      HALTED = 3'd4,
      FAULT  = 3'd5
   } state_t;

   state_t           cur_state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt_next;

   logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic is_load, is_store, is_op_imm, is_op, is_system;
   logic legal, is_mem_op, halt_cond, in_wait, timed_out;

   // Opcode classification shared by next-state and output logic.
   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_op_imm = (opcode == OPC_OP_IMM);
   assign is_op     = (opcode == OPC_OP);
   assign is_system = (opcode == OPC_SYSTEM);

   assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                      is_load | is_store | is_op_imm | is_op | is_system;
   assign is_mem_op = is_load | is_store;
   assign halt_cond = is_system & bit20;
   assign in_wait   = (cur_state == FETCH) || (cur_state == MEM);
   assign timed_out = TO_EN && (wait_cnt >= TO_LIM);

   // Next-state logic; a completing access wins over a timeout in the same cycle.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         FETCH: begin
            if (mem_ready)      next_state = DECODE;
            else if (timed_out) next_state = FAULT;
         end
         DECODE: begin
            if (!legal)                                next_state = FAULT;
            else if (is_mem_op || is_jalr || VISIT_MEM) next_state = MEM;
            else                                       next_state = EXEC;
         end
         MEM: begin
            if (!is_mem_op)     next_state = EXEC;
            else if (mem_ready) next_state = EXEC;
            else if (timed_out) next_state = FAULT;
         end
         EXEC:    next_state = halt_cond ? HALTED : FETCH;
         HALTED:  next_state = HALTED;
         FAULT:   next_state = FAULT;
         default: next_state = FAULT;
      endcase
   end

   // Wait counter: cleared on any state change, counts stalled cycles, saturates.
   always_comb begin
      cnt_next = wait_cnt;
      if (next_state != cur_state)
         cnt_next = '0;
      else if (in_wait && !mem_ready && (wait_cnt != CNT_MAX))
         cnt_next = wait_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= FETCH;
         wait_cnt  <= '0;
         halted    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         cur_state <= next_state;
         wait_cnt  <= cnt_next;
         halted    <= halted | (next_state == HALTED);
         fault     <= fault  | (next_state == FAULT);
      end
   end

   assign state = cur_state;

   // Datapath strobes; everything is held quiet while reset is asserted.
   always_comb begin
      retire       = 1'b0;
      pc_enable    = 1'b0;
      pc_load      = 1'b0;
      reg_re       = 1'b0;
      reg_we       = 1'b0;
      target_load  = 1'b0;
      mem_addr_sel = 1'b0;
      inst_load    = 1'b0;
      inst_mux_sel = 1'b0;
      alu_sel1     = 1'b0;
      alu_sel2     = 1'b0;
      alu_op       = 5'b00000;
      mem_read_op  = LNONE;
      mem_write_op = SNONE;

      if (is_jal || is_jalr) wd_sel = 2'b01;
      else if (is_load)      wd_sel = 2'b11;
      else                   wd_sel = 2'b00;

      if (!reset) begin
         case (cur_state)
            FETCH: mem_read_op = LW;
            DECODE: begin
               reg_re      = 1'b1;
               inst_load   = 1'b1;
               target_load = 1'b1;
               alu_sel1    = 1'b1;
               alu_sel2    = 1'b1;
            end
            MEM: begin
               mem_addr_sel = 1'b1;
               inst_mux_sel = 1'b1;
               if (is_load)  mem_read_op  = funct3;
               if (is_store) mem_write_op = funct3[1:0];
               if (is_jalr)  target_load  = 1'b1;
               if (is_mem_op || is_jalr) alu_sel2 = 1'b1;
            end
            EXEC: begin
               inst_mux_sel = 1'b1;
               reg_we    = is_op_imm | is_lui | is_op | is_auipc |
                           is_jal | is_jalr | is_load;
               pc_load   = is_jal | is_jalr | (is_branch & cmp_out);
               pc_enable = !halt_cond;
               retire    = !halt_cond;
               if (is_op || (is_op_imm && (funct3 == 3'b101)))
                  alu_op = {1'b0, bit30, funct3};
               else if (is_op_imm)
                  alu_op = {2'b00, funct3};
               else if (is_branch)
                  alu_op = {2'b10, funct3};
               if (is_auipc) begin
                  alu_sel1 = 1'b1;
                  alu_sel2 = 1'b1;
               end else if (is_op_imm || is_lui) begin
                  alu_sel2 = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter SKIP_MEM, default 1: 1 = non-memory ops (except JALR) go DECODE->EXEC directly; 0 = every instruction visits MEM for exactly one cycle.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum wait cycles per memory access; 0 disables the timeout.
REQ-003 SHALL have parameter CNT_W, default 5: wait-counter width; TIMEOUT < 2^CNT_W.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 opcode  in  7  instruction opcode field.
REQ-007 funct3  in  3  instruction funct3 field.
REQ-008 bit20, bit30  in  1 each  instruction bits 20 and 30.
REQ-009 cmp_out  in  1  branch comparator result.
REQ-010 mem_ready  in  1  memory completes the current access this cycle.
REQ-011 state  out  3  current state code.
REQ-012 halted, fault  out  1 each  sticky status flags.
REQ-013 retire  out  1  one-cycle pulse per completed instruction.
REQ-014 pc_enable, pc_load, reg_re, reg_we, target_load, mem_addr_sel, inst_load, inst_mux_sel  out  1 each  datapath strobes.
REQ-015 alu_sel1, alu_sel2  out  1 each; alu_op  out  5; wd_sel  out  2; mem_read_op  out  3; mem_write_op  out  2; all use the codebase's shared encodings (LW, LNONE, SNONE, opcode names).

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, MEM=2, EXEC=3, HALTED=4, FAULT=5.
REQ-017 FETCH: mem_read_op=LW; stay until mem_ready=1, then DECODE.
REQ-018 DECODE: reg_re, inst_load, target_load=1; alu_sel1=alu_sel2=1; always exactly one cycle.
REQ-019 DECODE with opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM} SHALL go to FAULT.
REQ-020 DECODE legal-opcode next state: MEM if opcode in {LOAD, STORE, JALR} or SKIP_MEM=0; else EXEC.
REQ-021 MEM: mem_addr_sel=1; LOAD drives mem_read_op=funct3, STORE drives mem_write_op=funct3[1:0], both held constant during waits; stay until mem_ready=1 for LOAD/STORE, one cycle otherwise; target_load=1 for JALR; alu_sel1=0, alu_sel2=1 for LOAD/STORE/JALR.
REQ-022 EXEC: one cycle; reg_we=1 for OP_IMM, LUI, OP, AUIPC, JAL, JALR, LOAD; pc_load=1 for JAL, JALR, or BRANCH with cmp_out=1; pc_enable=1 and retire=1 unless halt condition.
REQ-023 EXEC alu_op: OP or OP_IMM with funct3=101 -> {0,bit30,funct3}; other OP_IMM -> {00,funct3}; BRANCH -> {10,funct3}; else 0. AUIPC sel1=sel2=1; OP_IMM/LUI sel2=1 only.
REQ-024 Halt condition = opcode SYSTEM and bit20=1 in EXEC: next state HALTED, pc_enable=0, retire=0, no reg_we.
REQ-025 EXEC otherwise returns to FETCH.
REQ-026 wd_sel SHALL be 01 for JAL/JALR, 11 for LOAD, else 00 (all states).
REQ-027 inst_mux_sel=1 in MEM and EXEC only.
REQ-028 Wait counter SHALL clear on entering FETCH or MEM, increment each cycle mem_ready=0 in those states, saturate at 2^CNT_W-1.
REQ-029 If TIMEOUT>0 and counter reaches TIMEOUT with mem_ready still 0, next state SHALL be FAULT; mem_ready=1 in the same cycle wins (access completes).
REQ-030 HALTED and FAULT SHALL be absorbing until reset; all strobes 0, mem ops LNONE/SNONE; halted=1 in HALTED, fault=1 in FAULT.
REQ-031 All outputs except state/halted/fault SHALL be combinational from state, counter and inputs; no write strobe outside MEM.

Reset
REQ-032 reset=1 SHALL force state=FETCH, counter=0, halted=0, fault=0 at the next edge, from any state including mid-wait in MEM; reset dominates all transitions.
REQ-033 During reset cycles mem_write_op SHALL be SNONE and reg_we=0.

Verification
REQ-034 ADD (OP), mem_ready=1 always, SKIP_MEM=1 -> states 0,1,3,0; reg_we=1 and retire=1 in cycle 3; 3 cycles/instruction.
REQ-035 LW (LOAD, funct3=010), mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles, mem_read_op=010 throughout, reg_we=1 only in the following EXEC.
REQ-036 BEQ with cmp_out=1 then cmp_out=0 -> pc_load=1 then 0, alu_op=5'b10000 both; SKIP_MEM=0 run shows 4 cycles each.
REQ-037 EBREAK (SYSTEM, bit20=1) -> HALTED, pc_enable=0, retire=0, halted=1 held 10 cycles; reset -> FETCH.
REQ-038 TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 5th FETCH cycle; opcode 7'b0000000 at DECODE -> FAULT next cycle.
REQ-039 Reset asserted in MEM of SW with mem_ready=0 -> FETCH next cycle, mem_write_op=SNONE from reset cycle on.
